// File: rtl/flash_port_arbiter.sv
// flash_port_arbiter: shares one QSPI flash pad group between port A (core reader) and port B (host programmer).
// Compile-time option FLASH_ARB_TIMEOUT_EN adds a hold timeout that forces the owner off while the other port waits.
module flash_port_arbiter #(
    parameter int GAP_CYCLES     = 4,      // cycles of fcen high between owners, >= 1
    parameter int HOST_PRIO      = 0,      // 1: port B wins ties, 0: round-robin
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 65535   // >= 1, only used with FLASH_ARB_TIMEOUT_EN
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,

    input  logic       req_a,
    output logic       gnt_a,
    input  logic       cen_a,
    input  logic       sclk_a,
    input  logic [3:0] do_a,
    input  logic       doe_a,
    output logic [3:0] di_a,

    input  logic       req_b,
    output logic       gnt_b,
    input  logic       cen_b,
    input  logic       sclk_b,
    input  logic [3:0] do_b,
    input  logic       doe_b,
    output logic [3:0] di_b,

    input  logic [3:0] fdi,
    output logic       fcen,
    output logic       fsclk,
    output logic [3:0] fdo,
    output logic       fdoe,

    output logic       busy,
    output logic       owner,
    output logic       timeout_o,
    output logic [1:0] state_dbg
);

    // Handshake (req_x / gnt_x, level based): a port raises req_x and holds it for as
    // long as it needs the pads. gnt_x rises on the edge after req_x is sampled high in
    // IDLE, or on the edge ending a guard gap; it falls on the same edge that samples
    // req_x low. The port parks cen_x high before dropping req_x; the gap forces fcen
    // high regardless. Pad inputs of the port without the grant are ignored.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit               PRIO_B    = (HOST_PRIO != 0);

    state_t           state;
    state_t           state_next;
    logic             last_b;
    logic             last_b_next;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] gap_cnt_next;
    logic             enter_gap;
    logic             timeout_fire;
    logic             hold_expire;
    logic             arb_any;
    logic             arb_pick_b;

    assign di_a      = fdi;
    assign di_b      = fdi;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // B wins if alone, if it has priority, or if A was served last.
    assign arb_any    = req_a | req_b;
    assign arb_pick_b = req_b & (~req_a | PRIO_B | ~last_b);

    always_comb begin
        state_next   = state;
        last_b_next  = last_b;
        gap_cnt_next = gap_cnt;
        enter_gap    = 1'b0;
        timeout_fire = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    state_next = arb_pick_b ? GRANT_B : GRANT_A;
                end
            end
            GRANT_A: begin
                if (!req_a || hold_expire) begin
                    state_next   = GAP;
                    last_b_next  = 1'b0;
                    enter_gap    = 1'b1;
                    timeout_fire = req_a;  // still requesting: the release was forced
                end
            end
            GRANT_B: begin
                if (!req_b || hold_expire) begin
                    state_next   = GAP;
                    last_b_next  = 1'b1;
                    enter_gap    = 1'b1;
                    timeout_fire = req_b;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    if (arb_any) begin
                        state_next = arb_pick_b ? GRANT_B : GRANT_A;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    gap_cnt_next = gap_cnt - CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (enter_gap) begin
            gap_cnt_next = GAP_LOAD;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            last_b  <= 1'b1;
            gap_cnt <= '0;
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            owner   <= 1'b0;
        end else begin
            state   <= state_next;
            last_b  <= last_b_next;
            gap_cnt <= gap_cnt_next;
            gnt_a   <= (state_next == GRANT_A);
            gnt_b   <= (state_next == GRANT_B);
            if (state_next == GRANT_A) begin
                owner <= 1'b0;
            end else if (state_next == GRANT_B) begin
                owner <= 1'b1;
            end
        end
    end

    // Pads follow the owner combinationally; everywhere else the flash is parked deselected.
    always_comb begin
        fcen  = 1'b1;
        fsclk = 1'b0;
        fdo   = 4'h0;
        fdoe  = 1'b0;
        case (state)
            GRANT_A: begin
                fcen  = cen_a;
                fsclk = sclk_a;
                fdo   = do_a;
                fdoe  = doe_a;
            end
            GRANT_B: begin
                fcen  = cen_b;
                fsclk = sclk_b;
                fdo   = do_b;
                fdoe  = doe_b;
            end
            default: begin
                fcen  = 1'b1;
                fsclk = 1'b0;
                fdo   = 4'h0;
                fdoe  = 1'b0;
            end
        endcase
    end

`ifdef FLASH_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;
    logic             other_req;
    logic             timeout_q;

    assign other_req   = (state == GRANT_A) ? req_b :
                         (state == GRANT_B) ? req_a : 1'b0;
    assign hold_expire = other_req && (hold_cnt >= HOLD_LAST);
    assign timeout_o   = timeout_q;

    // Counts only cycles in which the other port is actually waiting; cleared between grants.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_fire;
            if ((state != GRANT_A) && (state != GRANT_B)) begin
                hold_cnt <= '0;
            end else if (other_req && (hold_cnt != {CNT_W{1'b1}})) begin
                hold_cnt <= hold_cnt + CNT_ONE;
            end
        end
    end
`else
    logic unused_timeout;

    assign hold_expire    = 1'b0;
    assign timeout_o      = 1'b0;
    assign unused_timeout = ^{HOLD_LAST, timeout_fire};
`endif

endmodule

// File: tb/tb_flash_port_arbiter.sv
// Testbench for flash_port_arbiter: two instances (round-robin and host priority) share one stimulus stream
// and are checked every cycle against a grant/gap/hold model, plus directed scenarios with literal expectations.
module tb_flash_port_arbiter;

  localparam int GAP = 4;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, cen_a, sclk_a, doe_a;
  logic [3:0] do_a;
  logic       req_b, cen_b, sclk_b, doe_b;
  logic [3:0] do_b;
  logic [3:0] fdi;

  logic [1:0] gnt_a_w, gnt_b_w, fcen_w, fsclk_w, fdoe_w, busy_w, owner_w, tmo_w;
  logic [3:0] di_a_w [2];
  logic [3:0] di_b_w [2];
  logic [3:0] fdo_w [2];
  logic [1:0] st_w [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    flash_port_arbiter #(
      .GAP_CYCLES(GAP),
      .HOST_PRIO(g),
      .CNT_W(16),
      .TIMEOUT_CYCLES(TMO)
    ) u_dut (
      .wb_clk_i(clk),
      .wb_rst_i(rst),
      .req_a(req_a),
      .gnt_a(gnt_a_w[g]),
      .cen_a(cen_a),
      .sclk_a(sclk_a),
      .do_a(do_a),
      .doe_a(doe_a),
      .di_a(di_a_w[g]),
      .req_b(req_b),
      .gnt_b(gnt_b_w[g]),
      .cen_b(cen_b),
      .sclk_b(sclk_b),
      .do_b(do_b),
      .doe_b(doe_b),
      .di_b(di_b_w[g]),
      .fdi(fdi),
      .fcen(fcen_w[g]),
      .fsclk(fsclk_w[g]),
      .fdo(fdo_w[g]),
      .fdoe(fdoe_w[g]),
      .busy(busy_w[g]),
      .owner(owner_w[g]),
      .timeout_o(tmo_w[g]),
      .state_dbg(st_w[g])
    );
  end

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // holder: -1 nobody, 0 port A, 1 port B. gap: guard cycles still to come.
  int m_holder [2];
  int m_gap    [2];
  int m_last   [2];
  int m_hold   [2];
  bit m_tmo    [2];
  bit model_on = 1'b0;

  function automatic int pick(int k, bit ra, bit rb);
    if (ra && rb) return (k == 1) ? 1 : ((m_last[k] == 1) ? 0 : 1);
    if (ra) return 0;
    if (rb) return 1;
    return -1;
  endfunction

  function automatic void model_step(int k, bit r, bit ra, bit rb);
    int nxt;
    m_tmo[k] = 1'b0;
    if (r) begin
      m_holder[k] = -1;
      m_gap[k]    = 0;
      m_last[k]   = 1;
      m_hold[k]   = 0;
      return;
    end
    if (m_holder[k] >= 0) begin
      bit mine;
      bit forced;
      mine   = (m_holder[k] == 0) ? ra : rb;
      forced = 1'b0;
`ifdef FLASH_ARB_TIMEOUT_EN
      if (mine && ((m_holder[k] == 0) ? rb : ra)) begin
        m_hold[k]++;
        forced = (m_hold[k] >= TMO);
      end
`endif
      if (!mine || forced) begin
        m_tmo[k]    = mine;
        m_last[k]   = m_holder[k];
        m_holder[k] = -1;
        m_gap[k]    = GAP;
      end
    end else if (m_gap[k] > 1) begin
      m_gap[k]--;
    end else begin
      m_gap[k] = 0;
      nxt = pick(k, ra, rb);
      if (nxt >= 0) begin
        m_holder[k] = nxt;
        m_hold[k]   = 0;
      end
    end
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k, rst, req_a, req_b);
  end

  // One compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      for (int k = 0; k < 2; k++) begin
        logic       e_cen, e_sclk, e_doe, e_busy;
        logic [3:0] e_do;
        e_cen = 1'b1; e_sclk = 1'b0; e_do = 4'h0; e_doe = 1'b0;
        if (m_holder[k] == 0) begin
          e_cen = cen_a; e_sclk = sclk_a; e_do = do_a; e_doe = doe_a;
        end else if (m_holder[k] == 1) begin
          e_cen = cen_b; e_sclk = sclk_b; e_do = do_b; e_doe = doe_b;
        end
        e_busy = (m_holder[k] >= 0) || (m_gap[k] > 0);
        chk($sformatf("m%0d.gnt_a", k), gnt_a_w[k], (m_holder[k] == 0));
        chk($sformatf("m%0d.gnt_b", k), gnt_b_w[k], (m_holder[k] == 1));
        chk($sformatf("m%0d.fcen", k), fcen_w[k], e_cen);
        chk($sformatf("m%0d.fsclk", k), fsclk_w[k], e_sclk);
        chk($sformatf("m%0d.fdo", k), fdo_w[k], e_do);
        chk($sformatf("m%0d.fdoe", k), fdoe_w[k], e_doe);
        chk($sformatf("m%0d.busy", k), busy_w[k], e_busy);
        chk($sformatf("m%0d.idle_dbg", k), (st_w[k] == 2'd0), !e_busy);
        chk($sformatf("m%0d.timeout", k), tmo_w[k], m_tmo[k]);
        chk($sformatf("m%0d.di_a", k), di_a_w[k], fdi);
        chk($sformatf("m%0d.di_b", k), di_b_w[k], fdi);
        if (m_holder[k] >= 0) chk($sformatf("m%0d.owner", k), owner_w[k], 4'(m_holder[k]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 0; k < 2; k++) begin
      m_holder[k] = -1; m_gap[k] = 0; m_last[k] = 1; m_hold[k] = 0; m_tmo[k] = 1'b0;
    end
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    cen_a = 1'b1; sclk_a = 1'b0; do_a = 4'h0; doe_a = 1'b0;
    cen_b = 1'b1; sclk_b = 1'b0; do_b = 4'h0; doe_b = 1'b0;
    fdi = 4'h0;
    tick();
    model_on = 1'b1;
    chk("rst.gnt_a", gnt_a_w[0], 1'b0);
    chk("rst.fcen", fcen_w[0], 1'b1);
    chk("rst.busy", busy_w[0], 1'b0);
    chk("rst.owner", owner_w[0], 1'b0);
    rst = 1'b0;

    // A alone: granted one edge later, pads follow A.
    req_a = 1'b1; cen_a = 1'b0; do_a = 4'hA; doe_a = 1'b1;
    tick();
    chk("a_only.gnt_a", gnt_a_w[0], 1'b1);
    chk("a_only.gnt_b", gnt_b_w[0], 1'b0);
    chk("a_only.fcen", fcen_w[0], 1'b0);
    chk("a_only.fdo", fdo_w[0], 4'hA);
    tick();
    do_a = 4'h5;
    #1 chk("a_only.fdo_track", fdo_w[0], 4'h5);

    // B waits, A releases: four guard cycles, then B.
    req_b = 1'b1; cen_b = 1'b0; do_b = 4'h3;
    tick();
    chk("wait.gnt_b", gnt_b_w[0], 1'b0);
    cen_a = 1'b1; req_a = 1'b0;
    tick();
    chk("gap.gnt_a_drop", gnt_a_w[0], 1'b0);
    for (int i = 0; i < GAP; i++) begin
      chk($sformatf("gap.fcen%0d", i), fcen_w[0], 1'b1);
      chk($sformatf("gap.gnt_b%0d", i), gnt_b_w[0], 1'b0);
      chk($sformatf("gap.fdo%0d", i), fdo_w[0], 4'h0);
      if (i < GAP - 1) tick();
    end
    tick();
    chk("gap.gnt_b_after", gnt_b_w[0], 1'b1);
    chk("gap.owner_b", owner_w[0], 1'b1);
    chk("gap.fdo_b", fdo_w[0], 4'h3);

    // Round-robin vs host priority from a simultaneous request.
    reset_pulse();
    req_a = 1'b1; req_b = 1'b1;
    tick();
    chk("rr.first_a", gnt_a_w[0], 1'b1);
    chk("prio.first_b", gnt_b_w[1], 1'b1);
    req_a = 1'b0;
    repeat (GAP + 1) tick();
    chk("rr.then_b", gnt_b_w[0], 1'b1);
    req_a = 1'b1; req_b = 1'b0;
    tick();
    req_b = 1'b1;
    repeat (GAP) tick();
    chk("rr.back_to_a", gnt_a_w[0], 1'b1);
    chk("prio.again_b", gnt_b_w[1], 1'b1);

    // Host priority, three simultaneous requests from idle.
    reset_pulse();
    for (int i = 0; i < 3; i++) begin
      req_a = 1'b1; req_b = 1'b1;
      tick();
      chk($sformatf("prio.tie%0d_b", i), gnt_b_w[1], 1'b1);
      chk($sformatf("prio.tie%0d_a", i), gnt_a_w[1], 1'b0);
      chk($sformatf("rr.tie%0d_a", i), gnt_a_w[0], (i % 2 == 0));
      req_a = 1'b0; req_b = 1'b0;
      repeat (GAP + 1) tick();
      chk($sformatf("prio.idle%0d", i), busy_w[1], 1'b0);
    end

    // Reset while B owns with cen_b low: no gap, pending A served right after.
    reset_pulse();
    req_b = 1'b1; cen_b = 1'b0; doe_b = 1'b1;
    tick();
    chk("rst_mid.gnt_b", gnt_b_w[0], 1'b1);
    req_a = 1'b1; rst = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_mid%0d.gnt_b", k), gnt_b_w[k], 1'b0);
      chk($sformatf("rst_mid%0d.fcen", k), fcen_w[k], 1'b1);
      chk($sformatf("rst_mid%0d.fdoe", k), fdoe_w[k], 1'b0);
      chk($sformatf("rst_mid%0d.busy", k), busy_w[k], 1'b0);
    end
    rst = 1'b0;
    tick();
    chk("rst_mid.a_after", gnt_a_w[0], 1'b1);
    chk("rst_mid.prio_b_after", gnt_b_w[1], 1'b1);

    // A holds while B waits.
    reset_pulse();
    req_a = 1'b1;
    tick();
    req_b = 1'b1;
`ifdef FLASH_ARB_TIMEOUT_EN
    for (int c = 1; c <= TMO + GAP; c++) begin
      tick();
      chk($sformatf("tmo.pulse%0d", c), tmo_w[0], (c == TMO));
      chk($sformatf("tmo.gnt_a%0d", c), gnt_a_w[0], (c < TMO));
      chk($sformatf("tmo.gnt_b%0d", c), gnt_b_w[0], (c == TMO + GAP));
    end
`else
    for (int c = 1; c <= 1000; c++) begin
      tick();
      chk("hold.gnt_a", gnt_a_w[0], 1'b1);
      chk("hold.timeout", tmo_w[0], 1'b0);
    end
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) req_a = ~req_a;
      if ($urandom_range(0, 7) == 0) req_b = ~req_b;
      cen_a  = 1'($urandom_range(0, 1));
      sclk_a = 1'($urandom_range(0, 1));
      doe_a  = 1'($urandom_range(0, 1));
      do_a   = 4'($urandom_range(0, 15));
      cen_b  = 1'($urandom_range(0, 1));
      sclk_b = 1'($urandom_range(0, 1));
      doe_b  = 1'($urandom_range(0, 1));
      do_b   = 4'($urandom_range(0, 15));
      fdi    = 4'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
